// File: rtl/proc_mem_port2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : proc_mem_port2_arbiter
// Description : Two-requester arbiter for memory port 2. Requester 0 is the
//               rx writer, requester 1 is the tx reader. One transfer per
//               cycle is granted. Under contention the requester that was
//               not served last wins, so the two alternate. The memory port
//               is driven combinationally from the granted requester. Read
//               data comes back one cycle later, qualified by rvalid0 or
//               rvalid1.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: PROC_MEM_ARB_LOCK_EN
//   When this macro is defined, the lock0 and lock1 inputs exist. If the
//   current owner holds its lock and keeps requesting, it keeps the port and
//   round robin is suspended. Without the macro, arbitration is pure round
//   robin.
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   req0/1, addr0/1, wr0/1,      requester transfer interfaces
//   wdata0/1, be0/1
//   lock0/1                      ownership lock (PROC_MEM_ARB_LOCK_EN only)
//   gnt0/1                       transfer accepted this cycle
//   rvalid0/1, rdata             read return, one cycle after the grant
//   mem_clken, mem_reset_req     memory stall / freeze inputs
//   mem_address, mem_byteenable, memory port-2 command
//   mem_chipselect, mem_write,
//   mem_writedata
//   mem_readdata                 memory port-2 read data (1-cycle latency)
// ============================================================================
module proc_mem_port2_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    // requester 0 (rx writer)
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              wr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [BE_W-1:0]   be0,
    // requester 1 (tx reader)
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              wr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [BE_W-1:0]   be1,
`ifdef PROC_MEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    // grants and read return
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    // memory port 2
    input  logic              mem_clken,
    input  logic              mem_reset_req,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;

    // Last-served pointer: 0 means requester 0 was served last, 1 means
    // requester 1. It is kept separate from the state so that it survives
    // IDLE. It resets to 1 so that requester 0 wins the first contention.
    logic       last_q;
    logic       last_d;

    // run_q is cleared asynchronously by reset and set on the first clock
    // edge after release. As a result, no grant can appear between the
    // rising edge of reset_n and the next clock edge. Because run_q is also
    // cleared immediately when reset asserts, it provides all the reset
    // gating for the combinational outputs.
    logic       run_q;

    logic       rvalid0_q;
    logic       rvalid1_q;

    logic       w_avail;
    logic       w_hold0;
    logic       w_hold1;
    logic       w_gnt0;
    logic       w_gnt1;

    assign w_avail = run_q & mem_clken & ~mem_reset_req;

    // ------------------------------------------------------------------------
    // Lock override: the current owner keeps the port while it holds its
    // lock and keeps requesting. The override ends as soon as either signal
    // drops, so no extra state is needed.
    // ------------------------------------------------------------------------
`ifdef PROC_MEM_ARB_LOCK_EN
    assign w_hold0 = (state_q == ST_OWN0) & lock0 & req0;
    assign w_hold1 = (state_q == ST_OWN1) & lock1 & req1;
`else
    assign w_hold0 = 1'b0;
    assign w_hold1 = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next state
    // A grant is issued only to an active requester, so a grant always means
    // the transfer completes at the coming edge. While the port is stalled
    // with requests still pending, the state holds so that any lock
    // ownership survives the stall.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (w_gnt0) begin
            state_d = ST_OWN0;
            last_d  = 1'b0;
        end else if (w_gnt1) begin
            state_d = ST_OWN1;
            last_d  = 1'b1;
        end else if (!req0 && !req1) begin
            state_d = ST_IDLE;
        end else if (state_q != ST_OWN0 && state_q != ST_OWN1) begin
            // also recovers the unused encoding
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 3: grant outputs
    // Priority: lock hold, then round robin under contention, then the sole
    // requester.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_avail) begin
            if (w_hold0) begin
                w_gnt0 = 1'b1;
            end else if (w_hold1) begin
                w_gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (last_q) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (req0) begin
                w_gnt0 = 1'b1;
            end else if (req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    // ------------------------------------------------------------------------
    // Run enable
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Read return tracking
    // The rvalid flags are not gated by mem_clken. The memory has already
    // produced the data for a read that was accepted. A read accepted just
    // before reset asserts is discarded by the asynchronous clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= w_gnt0 & ~wr0;
            rvalid1_q <= w_gnt1 & ~wr1;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = mem_readdata;

    // ------------------------------------------------------------------------
    // Memory command mux. The command bus is driven to zero when idle, so
    // stale requester fields never reach the memory.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (w_gnt0) begin
            mem_address    = addr0;
            mem_byteenable = be0;
            mem_chipselect = 1'b1;
            mem_write      = wr0;
            mem_writedata  = wdata0;
        end else if (w_gnt1) begin
            mem_address    = addr1;
            mem_byteenable = be1;
            mem_chipselect = 1'b1;
            mem_write      = wr1;
            mem_writedata  = wdata1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_port2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_mem_port2_arbiter
// Description : Self-checking bench for proc_mem_port2_arbiter. It contains a
//               memory model attached to port 2 and a behavioural reference
//               model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_mem_port2_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, wr0, wr1;
    logic [13:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  be0, be1;
`ifdef PROC_MEM_ARB_LOCK_EN
    logic        lock0, lock1;
`endif
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic        mem_clken, mem_reset_req;
    logic [13:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata = 16'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    proc_mem_port2_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0           (req0),
        .addr0          (addr0),
        .wr0            (wr0),
        .wdata0         (wdata0),
        .be0            (be0),
        .req1           (req1),
        .addr1          (addr1),
        .wr1            (wr1),
        .wdata1         (wdata1),
        .be1            (be1),
`ifdef PROC_MEM_ARB_LOCK_EN
        .lock0          (lock0),
        .lock1          (lock1),
`endif
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .rvalid0        (rvalid0),
        .rvalid1        (rvalid1),
        .rdata          (rdata),
        .mem_clken      (mem_clken),
        .mem_reset_req  (mem_reset_req),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    // ------------------------------------------------------------------------
    // Memory port-2 model: one-cycle read latency. Unwritten words read as 0.
    // ------------------------------------------------------------------------
    logic [15:0] mem [int];

    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                logic [15:0] v;
                v = mem.exists(int'(mem_address)) ? mem[int'(mem_address)] : 16'h0;
                if (mem_byteenable[0]) v[7:0]  = mem_writedata[7:0];
                if (mem_byteenable[1]) v[15:8] = mem_writedata[15:8];
                mem[int'(mem_address)] = v;
            end else begin
                mem_readdata <= mem.exists(int'(mem_address)) ? mem[int'(mem_address)] : 16'h0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model. The expected memory contents are built from the
    // requests that the model itself decides are granted.
    // ------------------------------------------------------------------------
    logic [15:0] ref_mem [int];
    int          m_last;   // requester served most recently (0/1)
    int          m_owner;  // -1 when no one owns the port, else 0/1
    int          m_rv;     // 0 none, 1 rvalid0, 2 rvalid1 expected
    logic [15:0] m_rdata;
    bit          m_run;

    // observed / expected values of the most recent cycle
    int          o_pick, e_pick, o_rv, e_rv;
    bit          o_cs, e_cs, o_we, e_we;
    logic [13:0] o_addr, e_addr;
    logic [15:0] o_wd, e_wd, o_rd, e_rd;

    function automatic int model_pick(bit r0, bit r1, bit l0, bit l1, bit ce, bit mrr);
        if (!m_run || !ce || mrr) return 0;
        if (m_owner == 0 && l0 && r0) return 1;
        if (m_owner == 1 && l1 && r1) return 2;
        if (r0 && r1) return (m_last == 1) ? 1 : 2;
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    function automatic logic [15:0] ref_read(logic [13:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
    endfunction

    task automatic ref_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] b);
        logic [15:0] v;
        v = ref_read(a);
        for (int k = 0; k < 2; k++) begin
            if (b[k]) v[k*8 +: 8] = d[k*8 +: 8];
        end
        ref_mem[int'(a)] = v;
    endtask

    // One clock cycle: drive on negedge, capture the command just before the
    // edge, advance the model at the edge, capture the read return after it.
    task automatic run_cycle(input bit r0, input bit r1, input bit w0, input bit w1,
                             input logic [13:0] a0, input logic [13:0] a1,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input logic [1:0] b0, input logic [1:0] b1,
                             input bit ce, input bit mrr, input bit l0, input bit l1);
        @(negedge clk);
        req0 = r0; req1 = r1; wr0 = w0; wr1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; be0 = b0; be1 = b1;
        mem_clken = ce; mem_reset_req = mrr;
`ifdef PROC_MEM_ARB_LOCK_EN
        lock0 = l0; lock1 = l1;
`endif
        #1;
        e_pick = model_pick(r0, r1, l0, l1, ce, mrr);
        o_pick = (gnt0 ? 1 : 0) + (gnt1 ? 2 : 0);
        o_cs = mem_chipselect; o_we = mem_write; o_addr = mem_address; o_wd = mem_writedata;
        e_cs = (e_pick != 0);
        e_we = (e_pick == 1) ? w0 : (e_pick == 2) ? w1 : 1'b0;
        e_addr = (e_pick == 2) ? a1 : a0;
        e_wd = (e_pick == 2) ? d1 : d0;
        @(posedge clk);
        m_rv = 0;
        if (e_pick == 1) begin
            m_last = 0; m_owner = 0;
            if (w0) ref_write(a0, d0, b0);
            else begin m_rv = 1; m_rdata = ref_read(a0); end
        end else if (e_pick == 2) begin
            m_last = 1; m_owner = 1;
            if (w1) ref_write(a1, d1, b1);
            else begin m_rv = 2; m_rdata = ref_read(a1); end
        end else if (!r0 && !r1) begin
            m_owner = -1;
        end
        m_run = 1;
        #1;
        o_rv = (rvalid0 ? 1 : 0) + (rvalid1 ? 2 : 0);
        o_rd = rdata;
        e_rv = m_rv;
        e_rd = m_rdata;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        req0 = 1; req1 = 1; wr0 = 0; wr1 = 1; addr0 = 0; addr1 = 0;
        wdata0 = 0; wdata1 = 0; be0 = 2'b11; be1 = 2'b11;
        mem_clken = 1; mem_reset_req = 0;
`ifdef PROC_MEM_ARB_LOCK_EN
        lock0 = 0; lock1 = 0;
`endif
        m_last = 1; m_owner = -1; m_rv = 0; m_run = 0; m_rdata = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if ({gnt1, gnt0} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {gnt1, gnt0}); end
        total++;
        if ({mem_chipselect, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_cs_we got=%b exp=00", {mem_chipselect, mem_write}); end
        total++;
        if ({rvalid1, rvalid0} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", {rvalid1, rvalid0}); end
        reset_n = 1'b1; #1;
        total++;
        if ({gnt1, gnt0} !== 2'b00) begin bad++; $display("FAIL release_gnt_before_edge got=%b exp=00", {gnt1, gnt0}); end
        @(posedge clk); m_run = 1; #1;
        total++;
        if ({rvalid1, rvalid0} !== 2'b00) begin bad++; $display("FAIL release_rvalid got=%b exp=00", {rvalid1, rvalid0}); end
        // first contention after reset goes to requester 0
        run_cycle(1, 1, 0, 0, 14'h1, 14'h2, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        total++;
        if (o_pick !== 1) begin bad++; $display("FAIL first_contention got=%0d exp=1", o_pick); end
        total++;
        if (o_rv !== e_rv) begin bad++; $display("FAIL first_contention_rvalid got=%0d exp=%0d", o_rv, e_rv); end
    endtask

    task automatic test_write_read();
        run_cycle(1, 0, 1, 0, 14'h0010, 14'h0, 16'hBEEF, 16'h0, 2'b11, 2'b00, 1, 0, 0, 0);
        total++;
        if (o_pick !== 1 || o_cs !== 1'b1 || o_we !== 1'b1) begin
            bad++; $display("FAIL wr_grant got pick=%0d cs=%0b we=%0b exp pick=1 cs=1 we=1", o_pick, o_cs, o_we);
        end
        total++;
        if (o_addr !== 14'h0010 || o_wd !== 16'hBEEF) begin
            bad++; $display("FAIL wr_cmd got addr=%h data=%h exp addr=0010 data=beef", o_addr, o_wd);
        end
        total++;
        if (o_rv !== 0) begin bad++; $display("FAIL wr_no_rvalid got=%0d exp=0", o_rv); end
        run_cycle(1, 0, 0, 0, 14'h0010, 14'h0, 16'h0, 16'h0, 2'b11, 2'b00, 1, 0, 0, 0);
        total++;
        if (o_pick !== 1 || o_we !== 1'b0) begin
            bad++; $display("FAIL rd_grant got pick=%0d we=%0b exp pick=1 we=0", o_pick, o_we);
        end
        total++;
        if (o_rv !== 1 || o_rd !== 16'hBEEF) begin
            bad++; $display("FAIL rd_return got rv=%0d data=%h exp rv=1 data=beef", o_rv, o_rd);
        end
    endtask

    task automatic test_alternate();
        // serve requester 1 alone so that the contention sequence starts at 0
        run_cycle(0, 1, 0, 0, 14'h0, 14'h0020, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_cycle(1, 1, 0, 0, 14'h0010, 14'h0020, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
            total++;
            if (o_pick !== ((i % 2 == 0) ? 1 : 2)) begin
                bad++; $display("FAIL alternate[%0d] got=%0d exp=%0d", i, o_pick, (i % 2 == 0) ? 1 : 2);
            end
            total++;
            if (o_rv !== e_rv || (e_rv != 0 && o_rd !== e_rd)) begin
                bad++; $display("FAIL alternate_rd[%0d] got rv=%0d data=%h exp rv=%0d data=%h", i, o_rv, o_rd, e_rv, e_rd);
            end
        end
    endtask

    task automatic test_clken_stall();
        run_cycle(1, 0, 0, 0, 14'h5, 14'h6, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1, 1, 0, 0, 14'h5, 14'h6, 0, 0, 2'b11, 2'b11, 0, 0, 0, 0);
            total++;
            if (o_pick !== 0 || o_cs !== 1'b0) begin
                bad++; $display("FAIL stall[%0d] got pick=%0d cs=%0b exp pick=0 cs=0", i, o_pick, o_cs);
            end
        end
        // last served before the stall was requester 0
        run_cycle(1, 1, 0, 0, 14'h5, 14'h6, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        total++;
        if (o_pick !== 2) begin bad++; $display("FAIL stall_resume0 got=%0d exp=2", o_pick); end
        run_cycle(1, 1, 0, 0, 14'h5, 14'h6, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        total++;
        if (o_pick !== 1) begin bad++; $display("FAIL stall_resume1 got=%0d exp=1", o_pick); end
    endtask

    task automatic test_mem_reset_req();
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 1, 0, 0, 14'h0, 14'h0010, 0, 0, 2'b11, 2'b11, 1, 1, 0, 0);
            total++;
            if (o_pick !== 0 || o_cs !== 1'b0) begin
                bad++; $display("FAIL frozen[%0d] got pick=%0d cs=%0b exp pick=0 cs=0", i, o_pick, o_cs);
            end
        end
        run_cycle(0, 1, 0, 0, 14'h0, 14'h0010, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        total++;
        if (o_pick !== 2) begin bad++; $display("FAIL unfrozen_gnt got=%0d exp=2", o_pick); end
        total++;
        if (o_rv !== 2 || o_rd !== 16'hBEEF) begin
            bad++; $display("FAIL unfrozen_rd got rv=%0d data=%h exp rv=2 data=beef", o_rv, o_rd);
        end
    endtask

    task automatic test_reset_mid_read();
        run_cycle(1, 0, 0, 0, 14'h3, 14'h4, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        @(negedge clk);
        req0 = 0; req1 = 1; wr1 = 0; addr1 = 14'h0010; mem_clken = 1; mem_reset_req = 0;
        #1;
        total++;
        if ({gnt1, gnt0} !== 2'b10) begin bad++; $display("FAIL midrst_gnt got=%b exp=10", {gnt1, gnt0}); end
        @(posedge clk); #1;
        reset_n = 1'b0; #1;
        total++;
        if ({rvalid1, rvalid0} !== 2'b00) begin bad++; $display("FAIL midrst_rvalid got=%b exp=00", {rvalid1, rvalid0}); end
        m_last = 1; m_owner = -1; m_rv = 0; m_run = 0;
        @(negedge clk);
        req0 = 0; req1 = 0; reset_n = 1'b1;
        @(posedge clk); m_run = 1; #1;
        total++;
        if ({rvalid1, rvalid0} !== 2'b00) begin bad++; $display("FAIL midrst_after got=%b exp=00", {rvalid1, rvalid0}); end
        run_cycle(0, 0, 0, 0, 14'h0, 14'h0, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        total++;
        if (o_rv !== 0) begin bad++; $display("FAIL midrst_idle_rvalid got=%0d exp=0", o_rv); end
        run_cycle(1, 1, 0, 0, 14'h0010, 14'h3, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        total++;
        if (o_pick !== 1) begin bad++; $display("FAIL midrst_contention got=%0d exp=1", o_pick); end
    endtask

`ifdef PROC_MEM_ARB_LOCK_EN
    task automatic test_lock();
        run_cycle(1, 0, 0, 0, 14'h7, 14'h8, 0, 0, 2'b11, 2'b11, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 1, 1, 0, 14'h7, 14'h8, 16'(i), 0, 2'b11, 2'b11, 1, 0, 1, 0);
            total++;
            if (o_pick !== 1) begin bad++; $display("FAIL lock_beat[%0d] got=%0d exp=1", i, o_pick); end
        end
        run_cycle(1, 1, 1, 0, 14'h7, 14'h8, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0);
        total++;
        if (o_pick !== 2) begin bad++; $display("FAIL lock_release got=%0d exp=2", o_pick); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit r0, r1, w0, w1, ce, mrr, l0, l1;
            r0  = ($urandom_range(0, 9) < 6);
            r1  = ($urandom_range(0, 9) < 6);
            w0  = $urandom_range(0, 1) != 0;
            w1  = $urandom_range(0, 1) != 0;
            ce  = ($urandom_range(0, 7) != 0);
            mrr = ($urandom_range(0, 15) == 0);
`ifdef PROC_MEM_ARB_LOCK_EN
            l0  = $urandom_range(0, 1) != 0;
            l1  = $urandom_range(0, 1) != 0;
`else
            l0  = 1'b0;
            l1  = 1'b0;
`endif
            run_cycle(r0, r1, w0, w1, 14'($urandom_range(0, 15)), 14'($urandom_range(0, 15)),
                      16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      ce, mrr, l0, l1);
            total++;
            if (o_pick !== e_pick || o_cs !== e_cs || o_we !== e_we) begin
                bad++; $display("FAIL rnd_grant[%0d] got pick=%0d cs=%0b we=%0b exp pick=%0d cs=%0b we=%0b",
                                i, o_pick, o_cs, o_we, e_pick, e_cs, e_we);
            end
            if (e_pick != 0) begin
                total++;
                if (o_addr !== e_addr || (e_we && o_wd !== e_wd)) begin
                    bad++; $display("FAIL rnd_cmd[%0d] got addr=%h data=%h exp addr=%h data=%h", i, o_addr, o_wd, e_addr, e_wd);
                end
            end
            total++;
            if (o_rv !== e_rv || (e_rv != 0 && o_rd !== e_rd)) begin
                bad++; $display("FAIL rnd_rd[%0d] got rv=%0d data=%h exp rv=%0d data=%h", i, o_rv, o_rd, e_rv, e_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_clken_stall();
        test_mem_reset_req();
        test_reset_mid_read();
`ifdef PROC_MEM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
